// File: rtl/determ_pkg.sv
// rtl/determ_pkg.sv - shared FSM encoding and width helpers for deterministic-bitstream controllers
//
// Contents:
//   S_IDLE / S_ACCUM / S_DONE : FSM state encoding
//   frac_bits(bw, iw)        : fraction bits of a signed fixed-point word
//   acc_width(lw)            : accumulator width for a 2^lw beat window of {-2,0,+2} deltas
package determ_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Sign bit plus integer bits take the rest of the word.
  function automatic int frac_bits(input int bw, input int iw);
    return bw - iw - 1;
  endfunction

  // |sum| <= 2 * 2^lw, so lw+2 magnitude bits plus a sign bit never overflow.
  function automatic int acc_width(input int lw);
    return lw + 3;
  endfunction

endpackage

// File: rtl/determ_add_avg_ctrl_if.sv
// rtl/determ_add_avg_ctrl_if.sv - beat/result handshake bundle for the bitstream averaging controller
//
// Signals:
//   start            : begin one averaging window
//   a, b             : bitstream bits (1 = +1, 0 = -1)
//   in_valid/in_ready: beat handshake
//   out_valid/out_ready: result handshake
//   y, sat           : signed fixed-point mean and clip flag
//   busy             : controller not idle
// Modports: master drives stimulus and consumes results, slave is the controller.
interface determ_add_avg_ctrl_if #(
  parameter int BIT_WIDTH = 16
);

  logic                 start;
  logic                 a;
  logic                 b;
  logic                 in_valid;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] y;
  logic                 sat;
  logic                 busy;

  modport master (
    output start, a, b, in_valid, out_ready,
    input  in_ready, out_valid, y, sat, busy
  );

  modport slave (
    input  start, a, b, in_valid, out_ready,
    output in_ready, out_valid, y, sat, busy
  );

endinterface

// File: rtl/determ_add_avg_ctrl.sv
// rtl/determ_add_avg_ctrl.sv - windowed mean of (a+b) over 2^LOG_WINDOW bitstream beats
//
// Ports:
//   CLK : sole clock, rising edge
//   RST : synchronous active-high reset
//   bus : determ_add_avg_ctrl_if.slave (start, a, b, in_valid, in_ready,
//         out_valid, out_ready, y, sat, busy)
// Parameters:
//   BIT_WIDTH  : output word width
//   INT_WIDTH  : integer bits of y excluding sign
//   LOG_WINDOW : window length is 2^LOG_WINDOW accepted beats
module determ_add_avg_ctrl
  import determ_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int INT_WIDTH  = 1,
  parameter int LOG_WINDOW = 4
) (
  input logic                CLK,
  input logic                RST,
  determ_add_avg_ctrl_if.slave bus
);

  localparam int FRAC    = frac_bits(BIT_WIDTH, INT_WIDTH);
  localparam int ACC_W   = acc_width(LOG_WINDOW);
  localparam int SHIFT   = FRAC - LOG_WINDOW;
  // Wide enough to hold the shifted sum before trimming to the output word.
  localparam int EXT_W   = (ACC_W + SHIFT > BIT_WIDTH) ? ACC_W + SHIFT : BIT_WIDTH;
  // mean >= 2^INT_WIDTH  <=>  acc >= 2^(INT_WIDTH+LOG_WINDOW)
  localparam int SAT_THR = 2 ** (INT_WIDTH + LOG_WINDOW);

  if (FRAC < LOG_WINDOW || LOG_WINDOW < 1) begin : g_param_check
    $error("determ_add_avg_ctrl: need FRAC >= LOG_WINDOW >= 1");
  end

  logic [1:0]              state;
  logic signed [ACC_W-1:0] acc;
  logic [LOG_WINDOW-1:0]   cnt;
  logic [BIT_WIDTH-1:0]    y_r;
  logic                    sat_r;

  logic                    beat;
  logic signed [ACC_W-1:0] delta;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [EXT_W-1:0] acc_ext;
  logic signed [31:0]      acc_int;
  logic [BIT_WIDTH-1:0]    y_next;
  logic                    sat_next;

  always_comb begin
    beat = bus.in_valid && (state == S_ACCUM);

    // (a?+1:-1)+(b?+1:-1): both high -> +2, both low -> -2, otherwise 0.
    delta = '0;
    case ({bus.a, bus.b})
      2'b11:   delta = ACC_W'(2);
      2'b00:   delta = ~ACC_W'(1);
      default: delta = '0;
    endcase

    acc_next = acc + delta;

    // Conversion uses the sum including the current beat so the result is
    // ready in the cycle DONE is entered.
    acc_ext  = EXT_W'(acc_next);
    acc_int  = 32'(acc_next);
    sat_next = (acc_int >= SAT_THR);
    y_next   = sat_next ? {1'b0, {(BIT_WIDTH-1){1'b1}}}
                        : BIT_WIDTH'(acc_ext <<< SHIFT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      y_r   <= '0;
      sat_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_ACCUM;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        S_ACCUM: begin
          if (beat) begin
            acc <= acc_next;
            cnt <= cnt + LOG_WINDOW'(1);
            if (&cnt) begin
              state <= S_DONE;
              y_r   <= y_next;
              sat_r <= sat_next;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_ACCUM);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.y         = y_r;
  assign bus.sat       = sat_r;

endmodule

// File: tb/tb_determ_add_avg_ctrl.sv
// tb/tb_determ_add_avg_ctrl.sv - scoreboard bench for determ_add_avg_ctrl at default parameters
module tb_determ_add_avg_ctrl;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  determ_add_avg_ctrl_if #(.BIT_WIDTH(16)) bus ();

  determ_add_avg_ctrl #(
    .BIT_WIDTH (16),
    .INT_WIDTH (1),
    .LOG_WINDOW(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int passed = 0;
  int total  = 0;
  int model_sum;
  logic [16:0] exp_q[$];
  logic [16:0] exp_v;

  // {sat, y}: mean = sum/16, y = mean * 2^14 = sum * 1024, clip at mean >= 2.
  function automatic logic [16:0] model_result(input int s);
    if (s >= 32) return {1'b1, 16'h7FFF};
    return {1'b0, 16'(s * 1024)};
  endfunction

  // All tasks start and end at a falling edge.
  task automatic drive_start();
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    model_sum = 0;
  endtask

  task automatic drive_beats(input logic [15:0] av, input logic [15:0] bv,
                             input int lo, input int hi,
                             input int gap_at, input int gap_len);
    for (int i = lo; i <= hi; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          bus.in_valid = 1'b0;
          bus.a        = 1'($urandom);
          bus.b        = 1'($urandom);
          bus.start    = 1'b1;
          @(negedge CLK);
        end
      end
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.a        = av[i];
      bus.b        = bv[i];
      model_sum   += (av[i] ? 1 : -1) + (bv[i] ? 1 : -1);
      @(negedge CLK);
    end
    bus.in_valid = 1'b0;
    if (hi == 15) exp_q.push_back(model_result(model_sum));
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.start = 1'b0; bus.a = 1'b0; bus.b = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    total++; if ({bus.sat, bus.y} !== 17'h0) $display("FAIL reset_y_sat: got sat=%b y=%h want 0/0000", bus.sat, bus.y); else passed++;
    bus.start = 1'b1; bus.in_valid = 1'b1; bus.a = 1'b1; bus.b = 1'b1; bus.out_ready = 1'b1;
    @(negedge CLK);
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_priority: busy=%b want 0", bus.busy); else passed++;
    RST = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge CLK);
    bus.start = 1'b0;
    total++; if ({bus.busy, bus.in_ready} !== 2'b11) $display("FAIL first_start: busy,in_ready=%b want 11", {bus.busy, bus.in_ready}); else passed++;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_from_accum: busy=%b want 0", bus.busy); else passed++;
  endtask

  task automatic test_all_ones();
    drive_start();
    drive_beats(16'hFFFF, 16'hFFFF, 0, 15, -1, 0);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL ones_latency: out_valid=%b want 1", bus.out_valid); else passed++;
    total++;
    if (exp_q.size() == 0) $display("FAIL ones_scoreboard: queue empty");
    else begin
      exp_v = exp_q.pop_front();
      if ({bus.sat, bus.y} !== exp_v) $display("FAIL ones_result: got sat=%b y=%h want sat=%b y=%h", bus.sat, bus.y, exp_v[16], exp_v[15:0]);
      else passed++;
    end
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
    total++; if ({bus.out_valid, bus.busy} !== 2'b00) $display("FAIL ones_release: out_valid,busy=%b want 00", {bus.out_valid, bus.busy}); else passed++;
  endtask

  task automatic test_all_zeros();
    drive_start();
    drive_beats(16'h0000, 16'h0000, 0, 15, -1, 0);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL zeros_latency: out_valid=%b want 1", bus.out_valid); else passed++;
    total++;
    if (exp_q.size() == 0) $display("FAIL zeros_scoreboard: queue empty");
    else begin
      exp_v = exp_q.pop_front();
      if ({bus.sat, bus.y} !== exp_v) $display("FAIL zeros_result: got sat=%b y=%h want sat=%b y=%h", bus.sat, bus.y, exp_v[16], exp_v[15:0]);
      else passed++;
    end
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_mixed();
    logic [15:0] bpat[2];
    bpat[0] = 16'h00FF;
    bpat[1] = 16'h0000;
    for (int w = 0; w < 2; w++) begin
      drive_start();
      drive_beats(16'hFFFF, bpat[w], 0, 15, -1, 0);
      total++;
      if (exp_q.size() == 0) $display("FAIL mixed_scoreboard: window %0d queue empty", w);
      else begin
        exp_v = exp_q.pop_front();
        if (bus.out_valid !== 1'b1 || {bus.sat, bus.y} !== exp_v)
          $display("FAIL mixed_result: window %0d got v=%b sat=%b y=%h want v=1 sat=%b y=%h", w, bus.out_valid, bus.sat, bus.y, exp_v[16], exp_v[15:0]);
        else passed++;
      end
      bus.out_ready = 1'b1;
      @(negedge CLK);
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_gaps_backpressure();
    drive_start();
    drive_beats(16'hB6D3, 16'h4E2D, 0, 14, 3, 5);
    total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) $display("FAIL gaps_count: after 15 beats out_valid,in_ready=%b want 01", {bus.out_valid, bus.in_ready}); else passed++;
    drive_beats(16'hB6D3, 16'h4E2D, 15, 15, -1, 0);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL gaps_latency: out_valid=%b want 1", bus.out_valid); else passed++;
    exp_v = 17'h0;
    total++;
    if (exp_q.size() == 0) $display("FAIL gaps_scoreboard: queue empty");
    else begin
      exp_v = exp_q.pop_front();
      if ({bus.sat, bus.y} !== exp_v) $display("FAIL gaps_result: got sat=%b y=%h want sat=%b y=%h", bus.sat, bus.y, exp_v[16], exp_v[15:0]);
      else passed++;
    end
    bus.start = 1'b1; bus.in_valid = 1'b1; bus.a = 1'b0; bus.b = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      total++;
      if (bus.out_valid !== 1'b1 || {bus.sat, bus.y} !== exp_v)
        $display("FAIL hold_stable: cycle %0d got v=%b sat=%b y=%h want v=1 sat=%b y=%h", c, bus.out_valid, bus.sat, bus.y, exp_v[16], exp_v[15:0]);
      else passed++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0; bus.out_ready = 1'b0;
    total++; if ({bus.out_valid, bus.busy} !== 2'b00) $display("FAIL handshake_idle: out_valid,busy=%b want 00", {bus.out_valid, bus.busy}); else passed++;
  endtask

  task automatic test_mid_reset();
    drive_start();
    drive_beats(16'hFFFF, 16'hFFFF, 0, 8, -1, 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    total++;
    if ({bus.out_valid, bus.in_ready, bus.busy, bus.sat, bus.y} !== 20'h0)
      $display("FAIL mid_reset: v=%b rdy=%b busy=%b sat=%b y=%h want all 0", bus.out_valid, bus.in_ready, bus.busy, bus.sat, bus.y);
    else passed++;
    bus.in_valid = 1'b1; bus.a = 1'b1; bus.b = 1'b1;
    repeat (3) @(negedge CLK);
    bus.in_valid = 1'b0;
    total++; if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b000) $display("FAIL idle_drop: busy,rdy,v=%b want 000", {bus.busy, bus.in_ready, bus.out_valid}); else passed++;
    drive_start();
    drive_beats(16'h0000, 16'h0000, 0, 15, -1, 0);
    total++;
    if (exp_q.size() == 0) $display("FAIL mid_reset_scoreboard: queue empty");
    else begin
      exp_v = exp_q.pop_front();
      if (bus.out_valid !== 1'b1 || {bus.sat, bus.y} !== exp_v)
        $display("FAIL mid_reset_result: got v=%b sat=%b y=%h want v=1 sat=%b y=%h", bus.out_valid, bus.sat, bus.y, exp_v[16], exp_v[15:0]);
      else passed++;
    end
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive_start();
    drive_beats(16'hFFFF, 16'hFFFF, 0, 15, -1, 0);
    total++;
    if (exp_q.size() == 0) $display("FAIL b2b_first_scoreboard: queue empty");
    else begin
      exp_v = exp_q.pop_front();
      if (bus.out_valid !== 1'b1 || {bus.sat, bus.y} !== exp_v)
        $display("FAIL b2b_first: got v=%b sat=%b y=%h want v=1 sat=%b y=%h", bus.out_valid, bus.sat, bus.y, exp_v[16], exp_v[15:0]);
      else passed++;
    end
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
    drive_start();
    total++; if ({bus.busy, bus.in_ready} !== 2'b11) $display("FAIL b2b_restart: busy,in_ready=%b want 11", {bus.busy, bus.in_ready}); else passed++;
    drive_beats(16'h0FFF, 16'hFF0F, 0, 15, -1, 0);
    total++;
    if (exp_q.size() == 0) $display("FAIL b2b_second_scoreboard: queue empty");
    else begin
      exp_v = exp_q.pop_front();
      if (bus.out_valid !== 1'b1 || {bus.sat, bus.y} !== exp_v)
        $display("FAIL b2b_second: got v=%b sat=%b y=%h want v=1 sat=%b y=%h", bus.out_valid, bus.sat, bus.y, exp_v[16], exp_v[15:0]);
      else passed++;
    end
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_mixed();
    test_gaps_backpressure();
    test_mid_reset();
    test_back_to_back();
    total++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d results left want 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/determ_add_avg_ctrl.md
DETERM_ADD_AVG_CTRL -- requirements
Module: determ_add_avg_ctrl

Interface
REQ-001 Parameters SHALL be:
- BIT_WIDTH, default 16: output word width.
- INT_WIDTH, default 1: integer bits excluding sign.
- LOG_WINDOW, default 4: window length = 2^LOG_WINDOW beats.
REQ-002 The derived constant FRAC SHALL be BIT_WIDTH-INT_WIDTH-1, and FRAC >= LOG_WINDOW SHALL hold (elaboration-time check).
REQ-003 Ports SHALL be:
- CLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  begin one averaging window.
- a, b  in  1 each  deterministic bitstream bits (1 = +1, 0 = -1).
- in_valid  in  1  a/b beat present.
- in_ready  out  1  controller accepts a beat.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- y  out  BIT_WIDTH  signed fixed-point window mean of (a+b): sign, INT_WIDTH integer bits, FRAC fraction bits.
- sat  out  1  y was clipped.
- busy  out  1  state != IDLE.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-005 IDLE: start=1 -> ACCUM next cycle; accumulator and beat counter cleared on that edge.
REQ-006 start SHALL be ignored in ACCUM and DONE, including the cycle of the output handshake.
REQ-007 in_ready SHALL equal (state==ACCUM); a beat is accepted iff in_valid & in_ready.
REQ-008 Per accepted beat, delta = (a?+1:-1)+(b?+1:-1), in {-2,0,+2}, SHALL be added to a signed accumulator of LOG_WINDOW+3 bits, which cannot overflow.
REQ-009 Cycles in ACCUM with in_valid=0 SHALL change neither accumulator nor counter.
REQ-010 On the 2^LOG_WINDOW-th accepted beat the state SHALL go to DONE next cycle, with out_valid=1 and y/sat valid in that cycle (latency 1 cycle after the last beat).
REQ-011 Result conversion: mean = acc / 2^LOG_WINDOW, i.e. y = acc << (FRAC-LOG_WINDOW), exact with no rounding.
REQ-012 If the mean >= 2^INT_WIDTH, y SHALL be the maximum positive value (0111..1) and sat=1; otherwise sat=0. The minimum -2 is representable when INT_WIDTH=1, so negative saturation SHALL NOT occur.
REQ-013 DONE: y, sat and out_valid SHALL be held stable while out_ready=0.
REQ-014 On out_valid & out_ready the state SHALL go to IDLE next cycle, with out_valid=0 in that next cycle.
REQ-015 busy SHALL be 1 in ACCUM and DONE.
REQ-016 Beats presented outside ACCUM SHALL be dropped with no state change.

Reset
REQ-017 RST=1 at a clock edge SHALL force, from any state including mid-window:
- state=IDLE
- accumulator=0 and counter=0
- y=0, sat=0
- out_valid=0, in_ready=0, busy=0
REQ-018 RST SHALL take priority over start, in_valid and out_ready in the same cycle.
REQ-019 The first start SHALL be honoured in the cycle after RST deasserts.

Structure
REQ-020 The FSM state encoding and the FRAC/accumulator-width derivations SHALL live in a shared package, determ_pkg, for reuse by other deterministic-bitstream controllers.
REQ-021 The block SHALL be a single module with no sub-module. Delta is computed inline, because determ_add's +2 result is not representable at INT_WIDTH=1.

Verification
REQ-022 The bench SHALL cover the following directed scenarios, all at defaults (window 16, FRAC 14):
- All-ones window: a=b=1 for 16 beats -> y=0x7FFF, sat=1, out_valid one cycle after the 16th beat.
- All-zeros window: a=b=0 for 16 beats -> y=0x8000 (-2.0), sat=0.
- Mixed window: a=1 throughout, b=1 for 8 beats then 0 for 8 beats -> y=0x4000 (+1.0). Separately, a=1,b=0 for 16 beats -> y=0x0000.
- Gaps and backpressure: in_valid low on beats 3-7 leaves the count unaffected. Then out_ready held low 5 cycles after out_valid -> y/out_valid stable. start pulsed during ACCUM and DONE -> ignored. One cycle after the handshake -> IDLE.
- Mid-window reset: RST asserted after beat 9 -> all outputs 0 and IDLE next cycle. A new start plus 16 beats of a=b=0 -> y=0x8000, unaffected by the earlier partial sum.
- Back-to-back windows: start asserted the cycle after the handshake -> second window result independent of the first.
